// File: rtl/uart_hex_pkg.sv
// Shared types, ASCII constants and the nibble-to-ASCII helper for the
// UART hex dumper.
package uart_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'h0, nib};
    end
    return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start request is honoured in IDLE, or on the last
// cycle of a stop bit so consecutive characters leave no idle gap.
// done is high on the final cycle of the stop bit.
module uart_tx_byte
  import uart_hex_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign done    = (state == STOP) && bit_end;

  // Frame FSM with baud and bit counters; tx is registered so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      if (state == IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            shift <= byte_in;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (start) begin
              shift <= byte_in;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_dumper.sv
// Renders accepted 32-bit words as 8 uppercase hex characters (MS nibble
// first), optionally followed by CR LF, and sends them 8N1 on tx.
module uart_hex_dumper
  import uart_hex_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          APPEND_CRLF  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  words_sent
);

  localparam logic [3:0] LAST_IDX = APPEND_CRLF ? 4'd9 : 4'd7;

  // word_sr keeps the nibble of the character on the wire in [31:28].
  logic [31:0] word_sr;
  logic [3:0]  char_idx;
  logic [3:0]  next_idx;
  logic [7:0]  next_byte;
  logic        accept;
  logic        byte_done;
  logic        last_char;
  logic        start_byte;

  assign accept     = word_valid && word_ready;
  assign last_char  = (char_idx == LAST_IDX);
  assign next_idx   = char_idx + 4'd1;
  assign start_byte = accept || (byte_done && !last_char);

  // First character comes straight from word_in so tx falls right after accept.
  always_comb begin
    next_byte = nibble_to_ascii(word_sr[27:24]);
    if (accept) begin
      next_byte = nibble_to_ascii(word_in[31:28]);
    end else if (next_idx == 4'd8) begin
      next_byte = ASCII_CR;
    end else if (next_idx == 4'd9) begin
      next_byte = ASCII_LF;
    end
  end

  // Handshake, character sequencing and the completed-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_sr    <= '0;
      char_idx   <= '0;
      busy       <= 1'b0;
      word_ready <= 1'b1;
      words_sent <= '0;
    end else if (accept) begin
      word_sr    <= word_in;
      char_idx   <= '0;
      busy       <= 1'b1;
      word_ready <= 1'b0;
    end else if (byte_done) begin
      if (last_char) begin
        busy       <= 1'b0;
        word_ready <= 1'b1;
        words_sent <= words_sent + 8'd1;
      end else begin
        char_idx <= next_idx;
        word_sr  <= {word_sr[27:0], 4'h0};
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk    (clk),
    .rst    (rst),
    .start  (start_byte),
    .byte_in(next_byte),
    .tx     (tx),
    .done   (byte_done)
  );

endmodule

// File: tb/tb_uart_hex_dumper.sv
// Bench for uart_hex_dumper: one instance with CR LF (4 clocks/bit) and one
// without (2 clocks/bit), driven through a shared word port gated by sel.
module tb_uart_hex_dumper;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wi;
  logic        wv;
  logic        sel;

  logic        wv_a, wv_b;
  logic        ready_a, tx_a, busy_a;
  logic        ready_b, tx_b, busy_b;
  logic [7:0]  ws_a, ws_b;
  logic        ready_o, tx_o, busy_o;
  logic [7:0]  ws_o;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_ws [2];
  string       hexd = "0123456789ABCDEF";
  bit          smp[$];

  always #5 clk = ~clk;

  assign wv_a    = wv & ~sel;
  assign wv_b    = wv & sel;
  assign ready_o = sel ? ready_b : ready_a;
  assign tx_o    = sel ? tx_b : tx_a;
  assign busy_o  = sel ? busy_b : busy_a;
  assign ws_o    = sel ? ws_b : ws_a;

  uart_hex_dumper #(.CLKS_PER_BIT(CPB_A), .APPEND_CRLF(1'b1)) u_dut (
    .clk(clk), .rst(rst), .word_in(wi), .word_valid(wv_a),
    .word_ready(ready_a), .tx(tx_a), .busy(busy_a), .words_sent(ws_a)
  );

  uart_hex_dumper #(.CLKS_PER_BIT(CPB_B), .APPEND_CRLF(1'b0)) u_dut_nc (
    .clk(clk), .rst(rst), .word_in(wi), .word_valid(wv_b),
    .word_ready(ready_b), .tx(tx_b), .busy(busy_b), .words_sent(ws_b)
  );

  function automatic int cpb();
    return sel ? CPB_B : CPB_A;
  endfunction

  function automatic int nchars();
    return sel ? 8 : 10;
  endfunction

  function automatic int t_word();
    return nchars() * 10 * cpb();
  endfunction

  // Expected text: "%08X" of the word, then CR LF on the CRLF instance.
  function automatic logic [7:0] exp_char(input logic [31:0] w, input int c);
    logic [31:0] t;
    logic [3:0]  nib;
    if (c == 8) return 8'h0D;
    if (c == 9) return 8'h0A;
    t   = w >> (28 - 4 * c);
    nib = t[3:0];
    return hexd[nib];
  endfunction

  // Decode one word's worth of per-cycle tx samples starting at smp[base].
  task automatic check_stream(input logic [31:0] w, input int base, input string tag);
    int n = cpb();
    for (int c = 0; c < nchars(); c++) begin
      bit         ok = 1'b1;
      logic [7:0] got = '0;
      for (int j = 0; j < 10; j++) begin
        int idx = base + (c * 10 + j) * n;
        bit lvl = smp[idx];
        for (int s = 1; s < n; s++) if (smp[idx + s] != lvl) ok = 1'b0;
        if (j == 0 && lvl != 1'b0) ok = 1'b0;
        if (j == 9 && lvl != 1'b1) ok = 1'b0;
        if (j >= 1 && j <= 8) got[j-1] = lvl;
      end
      checks++;
      if (!ok || got !== exp_char(w, c)) begin
        failures++;
        $display("FAIL %s char%0d word=%08h: got %02h framing_ok=%0d, expected %02h",
                 tag, c, w, got, ok, exp_char(w, c));
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = ready_o;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_ready: word_ready=%0b after %0d cycles, expected 1", ready_o, n);
    end
  endtask

  task automatic check_ws(input string tag);
    checks++;
    if (ws_o !== exp_ws[sel]) begin
      failures++;
      $display("FAIL %s words_sent: got %0d, expected %0d", tag, ws_o, exp_ws[sel]);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input string tag);
    bit ok;
    int t = t_word();
    int busy_cnt = 0;
    wait_ready(ok);
    if (!ok) return;
    wi = w;
    wv = 1'b1;
    @(posedge clk);
    smp.delete();
    for (int k = 1; k <= t; k++) begin
      @(negedge clk);
      smp.push_back(tx_o);
      if (busy_o) busy_cnt++;
      if (k == 1) begin
        wv = 1'b0;
        wi = $urandom;
      end
    end
    @(negedge clk);
    exp_ws[sel] = exp_ws[sel] + 8'd1;
    checks++;
    if (busy_cnt !== t) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", tag, busy_cnt, t);
    end
    checks++;
    if ({busy_o, ready_o, tx_o} !== 3'b011) begin
      failures++;
      $display("FAIL %s idle_after: busy/ready/tx got %0b%0b%0b, expected 011",
               tag, busy_o, ready_o, tx_o);
    end
    check_ws(tag);
    check_stream(w, 0, tag);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    wv  = 1'b0;
    wi  = '0;
    rst = 1'b1;
    exp_ws[0] = '0;
    exp_ws[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_a, ready_a, busy_a, ws_a, tx_b, ready_b, busy_b, ws_b} !==
          {3'b110, 8'd0, 3'b110, 8'd0}) begin
        failures++;
        $display("FAIL reset_idle cycle%0d: a tx/rdy/busy/ws=%0b%0b%0b/%0d b=%0b%0b%0b/%0d, expected 110/0",
                 i, tx_a, ready_a, busy_a, ws_a, tx_b, ready_b, busy_b, ws_b);
      end
    end
  endtask

  task automatic test_pattern();
    sel = 1'b0;
    send_word(32'h12AB34CD, "pattern_crlf");
  endtask

  task automatic test_no_crlf();
    sel = 1'b1;
    send_word(32'h00000000, "zeros_nocrlf");
    send_word(32'hFFFFFFFF, "ones_nocrlf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      sel = 1'($urandom_range(0, 1));
      send_word($urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t;
    sel = 1'b0;
    t   = t_word();
    wait_ready(ok);
    if (!ok) return;
    wi = 32'h0;
    wv = 1'b1;
    @(posedge clk);
    smp.delete();
    for (int cyc = 1; cyc <= 3 * t + 2; cyc++) begin
      int k = cyc / (t + 1);
      int r = cyc % (t + 1);
      @(negedge clk);
      smp.push_back(tx_o);
      if (r == 0) begin
        checks++;
        if ({busy_o, ready_o, tx_o} !== 3'b011) begin
          failures++;
          $display("FAIL b2b_gap cycle%0d: busy/ready/tx got %0b%0b%0b, expected 011",
                   cyc, busy_o, ready_o, tx_o);
        end
      end
      if (k < 2 && r == t / 2) wi = $urandom;
      if (k < 2 && r == t - 2) wi = 32'(k + 1);
      if (k == 2 && r == 5) wv = 1'b0;
    end
    @(negedge clk);
    exp_ws[0] = exp_ws[0] + 8'd3;
    checks++;
    if ({busy_o, ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_end: busy/ready got %0b%0b, expected 01", busy_o, ready_o);
    end
    check_ws("b2b");
    for (int k = 0; k < 3; k++) check_stream(32'(k), k * (t + 1), "b2b");
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_extra: busy got %0b, expected 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int target = 1 + (4 * 10 + 4) * CPB_A + 1;
    sel = 1'b0;
    wait_ready(ok);
    if (!ok) return;
    wi = 32'hDEAD0BEE;
    wv = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= target; k++) begin
      @(negedge clk);
      if (k == 1) wv = 1'b0;
    end
    checks++;
    if (tx_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_pre: tx got %0b, expected 0 (bit 3 of '0')", tx_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_a, busy_a, ready_a, ws_a} !== {3'b101, 8'd0}) begin
      failures++;
      $display("FAIL rst_mid_async: tx/busy/ready/ws got %0b%0b%0b/%0d, expected 101/0",
               tx_a, busy_a, ready_a, ws_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ws[0] = '0;
    exp_ws[1] = '0;
    send_word($urandom, "after_rst");
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    for (int i = 0; i < 256; i++) send_word($urandom, "wrap");
    check_ws("wrap_zero");
    send_word($urandom, "wrap_257");
  endtask

  initial begin
    rst = 1'b1;
    wv  = 1'b0;
    wi  = '0;
    sel = 1'b0;
    test_reset();
    test_pattern();
    test_no_crlf();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
